// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit.
// Takes a fetch_start pulse and a pc, issues one word read on the memory port,
// and presents the returned word to decode until it is accepted. Misaligned pc,
// bus errors and (optionally) a watchdog timeout are reported as faults that
// persist until a flush. A flush abandons the fetch, but a request already on
// the bus is never withdrawn: it is drained in DROP and its data is discarded.
// All outputs are registered.
//
// Optional feature: define IFETCH_TIMEOUT_EN to add a REQ/DROP watchdog of
// TIMEOUT_CYCLES cycles. Without it, REQ and DROP wait indefinitely.
module instr_fetch #(
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic [22:0] pc,
    input  logic        pc_misaligned,
    input  logic        flush,
    output logic        mem_req,
    output logic [22:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [22:0] instr_pc,
    input  logic        instr_ready,
    output logic        fault,
    output logic [1:0]  fault_cause,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DROP  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUS      = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

    state_t      state_reg;
    state_t      state_next;
    logic        wd_expired;

    logic        mem_req_next;
    logic [22:0] mem_addr_next;
    logic        instr_valid_next;
    logic [31:0] instr_next;
    logic [22:0] instr_pc_next;
    logic        fault_next;
    logic [1:0]  fault_cause_next;
    logic        busy_next;

`ifdef IFETCH_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_reg;
    logic            in_wait;
    logic            stay_wait;

    assign in_wait    = (state_reg == REQ) || (state_reg == DROP);
    assign stay_wait  = (state_next == REQ) || (state_next == DROP);
    // Expires on the last allowed waiting cycle, so mem_req is high for exactly
    // TIMEOUT_CYCLES cycles before it drops.
    assign wd_expired = in_wait && (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts consecutive cycles spent waiting in REQ/DROP, cleared otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_reg <= '0;
        end else if (in_wait && stay_wait) begin
            wd_reg <= wd_reg + WD_W'(1);
        end else begin
            wd_reg <= '0;
        end
    end
`else
    // No watchdog: the limit is never reached (a negative limit is meaningless).
    assign wd_expired = (TIMEOUT_CYCLES < 0);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: ack beats timeout, flush abandons but never withdraws a request
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (fetch_start && !flush) begin
                    state_next = pc_misaligned ? FAULT : REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    if (flush) begin
                        state_next = IDLE;
                    end else begin
                        state_next = mem_err ? FAULT : HOLD;
                    end
                end else if (flush) begin
                    // If the watchdog retires the request this cycle there is nothing left to drain.
                    state_next = wd_expired ? IDLE : DROP;
                end else if (wd_expired) begin
                    state_next = FAULT;
                end
            end
            DROP: begin
                if (mem_ack || wd_expired) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (instr_ready || flush) begin
                    state_next = IDLE;
                end
            end
            FAULT: begin
                if (flush) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, derived from the transition
    always_comb begin
        mem_req_next     = (state_next == REQ) || (state_next == DROP);
        busy_next        = (state_next != IDLE);
        instr_valid_next = (state_next == HOLD);
        fault_next       = (state_next == FAULT);
        mem_addr_next    = mem_addr;
        instr_next       = instr;
        instr_pc_next    = instr_pc;
        fault_cause_next = CAUSE_NONE;

        // Aligned pc is guaranteed here: a misaligned pc goes to FAULT instead.
        if (state_reg == IDLE && state_next == REQ) begin
            mem_addr_next = pc;
        end

        if (state_reg == REQ && state_next == HOLD) begin
            instr_next    = mem_rdata;
            instr_pc_next = mem_addr;
        end

        if (state_next == FAULT) begin
            if (state_reg == FAULT) begin
                fault_cause_next = fault_cause;
            end else if (state_reg == IDLE) begin
                fault_cause_next = CAUSE_MISALIGN;
            end else if (mem_ack) begin
                fault_cause_next = CAUSE_BUS;
            end else begin
                fault_cause_next = CAUSE_TIMEOUT;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
            busy        <= 1'b0;
        end else begin
            mem_req     <= mem_req_next;
            mem_addr    <= mem_addr_next;
            instr_valid <= instr_valid_next;
            instr       <= instr_next;
            instr_pc    <= instr_pc_next;
            fault       <= fault_next;
            fault_cause <= fault_cause_next;
            busy        <= busy_next;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven check of instr_fetch, one vector per clock,
// followed by hand-written watchdog / long-wait sequences.
// With IFETCH_TIMEOUT_EN defined the watchdog limit is 8 cycles.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [22:0] pc;
    logic        pc_misaligned;
    logic        flush;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        instr_valid;
    logic [31:0] instr;
    logic [22:0] instr_pc;
    logic        instr_ready;
    logic        fault;
    logic [1:0]  fault_cause;
    logic        busy;

    int tests    = 0;
    int failures = 0;

    instr_fetch #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc(pc),
        .pc_misaligned(pc_misaligned), .flush(flush), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mem_err(mem_err), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready), .fault(fault),
        .fault_cause(fault_cause), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic [22:0] pc;
        logic        mis;
        logic        flush;
        logic        ack;
        logic [31:0] rdata;
        logic        err;
        logic        ready;
        logic        e_req;
        logic [22:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [22:0] e_ipc;
        logic        e_fault;
        logic [1:0]  e_cause;
        logic        e_busy;
    } vec_t;

    localparam int NV = 34;
    localparam logic [31:0] I0 = 32'h00500093;
    localparam logic [31:0] I1 = 32'h12345678;
    localparam logic [31:0] I2 = 32'hAAAA5555;

    vec_t v [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("[TB] %s ok (%h)", name, act);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b1; fetch_start = 1'b0; pc = '0; pc_misaligned = 1'b0;
        flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0; mem_err = 1'b0; instr_ready = 1'b0;
    endtask

    initial begin
        int n;
        //        rst start pc       mis fl  ack rdata          err rdy | req addr     iv instr         ipc      f  c     busy
        v[0]  = '{0, 0, 23'h000000, 0, 0, 0, 32'h0,         0, 0,  0, 23'h000000, 0, 32'h0,        23'h000000, 0, 2'd0, 0};
        v[1]  = '{1, 0, 23'h000000, 0, 0, 0, 32'h0,         0, 0,  0, 23'h000000, 0, 32'h0,        23'h000000, 0, 2'd0, 0};
        v[2]  = '{1, 1, 23'h000010, 0, 0, 0, 32'h0,         0, 0,  1, 23'h000010, 0, 32'h0,        23'h000000, 0, 2'd0, 1};
        v[3]  = '{1, 0, 23'h000000, 0, 0, 0, 32'h0,         0, 0,  1, 23'h000010, 0, 32'h0,        23'h000000, 0, 2'd0, 1};
        v[4]  = '{1, 0, 23'h000000, 0, 0, 0, 32'h0,         0, 0,  1, 23'h000010, 0, 32'h0,        23'h000000, 0, 2'd0, 1};
        v[5]  = '{1, 0, 23'h000000, 0, 0, 1, I0,            0, 0,  0, 23'h000010, 1, I0,           23'h000010, 0, 2'd0, 1};
        v[6]  = '{1, 1, 23'h000040, 0, 0, 0, 32'h0,         0, 0,  0, 23'h000010, 1, I0,           23'h000010, 0, 2'd0, 1};
        v[7]  = '{1, 0, 23'h000000, 0, 0, 0, 32'h0,         0, 1,  0, 23'h000010, 0, I0,           23'h000010, 0, 2'd0, 0};
        v[8]  = '{1, 1, 23'h000012, 1, 0, 0, 32'h0,         0, 0,  0, 23'h000010, 0, I0,           23'h000010, 1, 2'd1, 1};
        v[9]  = '{1, 0, 23'h000000, 0, 0, 1, 32'hFFFFFFFF,  0, 0,  0, 23'h000010, 0, I0,           23'h000010, 1, 2'd1, 1};
        v[10] = '{1, 0, 23'h000000, 0, 1, 0, 32'h0,         0, 0,  0, 23'h000010, 0, I0,           23'h000010, 0, 2'd0, 0};
        v[11] = '{1, 1, 23'h000020, 0, 0, 0, 32'h0,         0, 0,  1, 23'h000020, 0, I0,           23'h000010, 0, 2'd0, 1};
        v[12] = '{1, 0, 23'h000000, 0, 1, 0, 32'h0,         0, 0,  1, 23'h000020, 0, I0,           23'h000010, 0, 2'd0, 1};
        v[13] = '{1, 0, 23'h000000, 0, 0, 0, 32'h0,         0, 0,  1, 23'h000020, 0, I0,           23'h000010, 0, 2'd0, 1};
        v[14] = '{1, 0, 23'h000000, 0, 0, 1, 32'hDEADBEEF,  0, 0,  0, 23'h000020, 0, I0,           23'h000010, 0, 2'd0, 0};
        v[15] = '{1, 0, 23'h000000, 0, 0, 0, 32'h0,         0, 0,  0, 23'h000020, 0, I0,           23'h000010, 0, 2'd0, 0};
        v[16] = '{1, 1, 23'h000030, 0, 0, 0, 32'h0,         0, 0,  1, 23'h000030, 0, I0,           23'h000010, 0, 2'd0, 1};
        v[17] = '{1, 0, 23'h000000, 0, 0, 1, 32'h11111111,  1, 0,  0, 23'h000030, 0, I0,           23'h000010, 1, 2'd2, 1};
        v[18] = '{1, 1, 23'h000034, 0, 0, 0, 32'h0,         0, 0,  0, 23'h000030, 0, I0,           23'h000010, 1, 2'd2, 1};
        v[19] = '{1, 0, 23'h000000, 0, 1, 0, 32'h0,         0, 0,  0, 23'h000030, 0, I0,           23'h000010, 0, 2'd0, 0};
        v[20] = '{1, 1, 23'h000044, 0, 1, 0, 32'h0,         0, 0,  0, 23'h000030, 0, I0,           23'h000010, 0, 2'd0, 0};
        v[21] = '{1, 1, 23'h000050, 0, 0, 0, 32'h0,         0, 0,  1, 23'h000050, 0, I0,           23'h000010, 0, 2'd0, 1};
        v[22] = '{1, 0, 23'h000000, 0, 1, 1, 32'h22222222,  0, 0,  0, 23'h000050, 0, I0,           23'h000010, 0, 2'd0, 0};
        v[23] = '{1, 1, 23'h000060, 0, 0, 0, 32'h0,         0, 0,  1, 23'h000060, 0, I0,           23'h000010, 0, 2'd0, 1};
        v[24] = '{1, 0, 23'h000000, 0, 0, 1, I1,            0, 0,  0, 23'h000060, 1, I1,           23'h000060, 0, 2'd0, 1};
        v[25] = '{0, 0, 23'h000000, 0, 0, 0, 32'h0,         0, 0,  0, 23'h000000, 0, 32'h0,        23'h000000, 0, 2'd0, 0};
        v[26] = '{0, 1, 23'h000070, 0, 0, 0, 32'h0,         0, 0,  0, 23'h000000, 0, 32'h0,        23'h000000, 0, 2'd0, 0};
        v[27] = '{1, 0, 23'h000000, 0, 0, 0, 32'h0,         0, 0,  0, 23'h000000, 0, 32'h0,        23'h000000, 0, 2'd0, 0};
        v[28] = '{1, 1, 23'h000080, 0, 0, 0, 32'h0,         0, 0,  1, 23'h000080, 0, 32'h0,        23'h000000, 0, 2'd0, 1};
        v[29] = '{1, 0, 23'h000000, 0, 0, 1, I2,            0, 0,  0, 23'h000080, 1, I2,           23'h000080, 0, 2'd0, 1};
        v[30] = '{1, 0, 23'h000000, 0, 1, 0, 32'h0,         0, 0,  0, 23'h000080, 0, I2,           23'h000080, 0, 2'd0, 0};
        v[31] = '{1, 1, 23'h000090, 0, 0, 0, 32'h0,         0, 0,  1, 23'h000090, 0, I2,           23'h000080, 0, 2'd0, 1};
        v[32] = '{0, 0, 23'h000000, 0, 0, 0, 32'h0,         0, 0,  0, 23'h000000, 0, 32'h0,        23'h000000, 0, 2'd0, 0};
        v[33] = '{1, 0, 23'h000000, 0, 0, 0, 32'h0,         0, 0,  0, 23'h000000, 0, 32'h0,        23'h000000, 0, 2'd0, 0};

        idle_inputs();
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset = v[i].rst_n; fetch_start = v[i].start; pc = v[i].pc;
            pc_misaligned = v[i].mis; flush = v[i].flush; mem_ack = v[i].ack;
            mem_rdata = v[i].rdata; mem_err = v[i].err; instr_ready = v[i].ready;
            @(posedge clk);
            #1;
            tests++;
            if ({mem_req, mem_addr, instr_valid, instr, instr_pc, fault, fault_cause, busy} !==
                {v[i].e_req, v[i].e_addr, v[i].e_iv, v[i].e_instr, v[i].e_ipc, v[i].e_fault, v[i].e_cause, v[i].e_busy}) begin
                failures++;
                $display("FAIL vec%0d: got req=%b addr=%h iv=%b instr=%h ipc=%h fault=%b cause=%0d busy=%b, expected req=%b addr=%h iv=%b instr=%h ipc=%h fault=%b cause=%0d busy=%b",
                         i, mem_req, mem_addr, instr_valid, instr, instr_pc, fault, fault_cause, busy,
                         v[i].e_req, v[i].e_addr, v[i].e_iv, v[i].e_instr, v[i].e_ipc, v[i].e_fault, v[i].e_cause, v[i].e_busy);
            end else begin
                $display("[TB] vec%0d ok: req=%b addr=%h iv=%b instr=%h fault=%b cause=%0d busy=%b",
                         i, mem_req, mem_addr, instr_valid, instr, fault, fault_cause, busy);
            end
        end

        // Long wait in REQ with no ack
        @(negedge clk);
        idle_inputs();
        fetch_start = 1'b1; pc = 23'h000100;
        @(negedge clk);
        fetch_start = 1'b0;
        n = 0;
`ifdef IFETCH_TIMEOUT_EN
        while (mem_req === 1'b1 && n < 600) begin
            n++;
            @(negedge clk);
        end
        chk("wd_req_cycles", 32'(n), 32'd8);
        chk("wd_fault", {31'b0, fault}, 32'd1);
        chk("wd_cause", {30'b0, fault_cause}, 32'd3);
        chk("wd_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("wd_flush_fault", {31'b0, fault}, 32'd0);
        chk("wd_flush_cause", {30'b0, fault_cause}, 32'd0);

        // Watchdog expiring while draining a flushed request ends in IDLE, no fault
        fetch_start = 1'b1; pc = 23'h000104;
        @(negedge clk);
        fetch_start = 1'b0;
        flush = 1'b1;
        n = 0;
        while (mem_req === 1'b1 && n < 600) begin
            n++;
            @(negedge clk);
            flush = 1'b0;
        end
        chk("wd_drop_cycles", 32'(n), 32'd8);
        chk("wd_drop_fault", {31'b0, fault}, 32'd0);
        chk("wd_drop_busy", {31'b0, busy}, 32'd0);
`else
        while (mem_req === 1'b1 && n < 500) begin
            n++;
            @(negedge clk);
        end
        chk("nowd_req_cycles", 32'(n), 32'd500);
        chk("nowd_req_still", {31'b0, mem_req}, 32'd1);
        chk("nowd_fault", {31'b0, fault}, 32'd0);
        chk("nowd_busy", {31'b0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("nowd_drop_req", {31'b0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("nowd_drop_busy", {31'b0, busy}, 32'd0);
        chk("nowd_drop_iv", {31'b0, instr_valid}, 32'd0);
        chk("nowd_drop_instr", instr, 32'h00000000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 200, giving the REQ-state watchdog limit in cycles; it is used only with IFETCH_TIMEOUT_EN.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-low.
REQ-004 The block SHALL have port fetch_start  input  1  one-cycle pulse requesting a fetch at pc.
REQ-005 The block SHALL have port pc  input  23  byte address from the instruction counter.
REQ-006 The block SHALL have port pc_misaligned  input  1  pc[1:0] != 0.
REQ-007 The block SHALL have port flush  input  1  abandon the current fetch (jump/interrupt/MRET).
REQ-008 The block SHALL have port mem_req  output  1  memory read request.
REQ-009 The block SHALL have port mem_addr  output  23  read address, word aligned.
REQ-010 The block SHALL have port mem_ack  input  1  read complete, one-cycle pulse.
REQ-011 The block SHALL have port mem_rdata  input  32  read data, valid with mem_ack.
REQ-012 The block SHALL have port mem_err  input  1  bus error, valid with mem_ack.
REQ-013 The block SHALL have port instr_valid  output  1  instruction available to decode.
REQ-014 The block SHALL have port instr  output  32  fetched instruction word.
REQ-015 The block SHALL have port instr_pc  output  23  address of instr.
REQ-016 The block SHALL have port instr_ready  input  1  decode accepts instr.
REQ-017 The block SHALL have ports fault  output  1  and fault_cause  output  2: 00 none, 01 misaligned, 10 bus error, 11 timeout.
REQ-018 The block SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, DROP, HOLD, FAULT, and all outputs SHALL be registered.
REQ-020 In IDLE, when fetch_start=1 and flush=0, the block SHALL go to FAULT with cause 01 if pc_misaligned=1; otherwise it SHALL latch mem_addr=pc and go to REQ.
REQ-021 In REQ, mem_req SHALL be 1 and mem_addr SHALL be held stable; the first mem_req SHALL occur at cycle n+1 after fetch_start at cycle n.
REQ-022 In REQ, mem_ack=1 with mem_err=1 SHALL go to FAULT with cause 10.
REQ-023 In REQ, mem_ack=1 with mem_err=0 SHALL latch instr=mem_rdata and instr_pc=mem_addr and go to HOLD, so instr_valid rises at cycle m+1 for an ack at cycle m.
REQ-024 flush in REQ without mem_ack SHALL go to DROP; flush together with mem_ack SHALL go to IDLE, discarding data and err.
REQ-025 In DROP, mem_req SHALL stay 1 until mem_ack (a request is never withdrawn), then the block SHALL go to IDLE with no fault and instr unchanged.
REQ-026 In HOLD, instr_valid SHALL be 1 with instr and instr_pc stable; instr_ready=1 or flush=1 SHALL go to IDLE with instr_valid=0 on the next cycle.
REQ-027 In FAULT, fault SHALL be 1 and fault_cause held; only flush SHALL return to IDLE, clearing fault and setting fault_cause to 00.
REQ-028 fetch_start outside IDLE, and mem_ack outside REQ/DROP, SHALL be ignored; in IDLE, flush SHALL override a simultaneous fetch_start.
REQ-029 At most one memory transaction SHALL be outstanding.

Reset
REQ-030 When reset=0 at a clock edge, the block SHALL enter IDLE and set mem_req, mem_addr, instr_valid, instr, instr_pc, fault, fault_cause, busy and the watchdog to 0, overriding every other input, including mid-transaction.

Configuration
REQ-031 With IFETCH_TIMEOUT_EN defined, a counter SHALL count cycles spent in REQ or DROP; reaching TIMEOUT_CYCLES without mem_ack SHALL deassert mem_req and go to FAULT with cause 11 from REQ, or to IDLE from DROP.
REQ-032 Without IFETCH_TIMEOUT_EN, no counter SHALL exist, REQ and DROP SHALL wait indefinitely, and cause 11 SHALL never occur.

Verification
REQ-033 Bench SHALL check: pc=0x000010, fetch_start, ack after 3 cycles with rdata=0x00500093 -> instr_valid with instr=0x00500093, instr_pc=0x000010; instr_ready -> IDLE.
REQ-034 Bench SHALL check: pc=0x000012, pc_misaligned=1, fetch_start -> no mem_req, fault=1, cause=01; flush -> fault=0, cause=00.
REQ-035 Bench SHALL check: flush while in REQ, ack 2 cycles later -> mem_req held until ack, then IDLE, instr_valid never 1.
REQ-036 Bench SHALL check: ack with mem_err=1 -> fault=1, cause=10; reset=0 while in HOLD -> all outputs 0 next cycle.
REQ-037 Bench SHALL check: with IFETCH_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> mem_req drops after 8 cycles, cause=11; without the macro, mem_req still high after 500 cycles.
